// File: rtl/harmonic_sum_pkg.sv
// Shared types, widths and the reciprocal ROM for the harmonic-sum engine.
`default_nettype none

package harmonic_sum_pkg;

  localparam int N_W    = 5;
  localparam int SUM_W  = 20;
  localparam int FRAC_W = 16;
  localparam int K_W    = N_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ACCUM = 2'd2,
    DONE  = 2'd3
  } state_t;

  // floor(65536 / k) in Q1.16; k = 0 and k > 31 never occur.
  function automatic logic [SUM_W-1:0] recip(input logic [K_W-1:0] k);
    logic [FRAC_W:0] r;
    case (k)
      6'd1:    r = 17'h10000;
      6'd2:    r = 17'h08000;
      6'd3:    r = 17'h05555;
      6'd4:    r = 17'h04000;
      6'd5:    r = 17'h03333;
      6'd6:    r = 17'h02AAA;
      6'd7:    r = 17'h02492;
      6'd8:    r = 17'h02000;
      6'd9:    r = 17'h01C71;
      6'd10:   r = 17'h01999;
      6'd11:   r = 17'h01745;
      6'd12:   r = 17'h01555;
      6'd13:   r = 17'h013B1;
      6'd14:   r = 17'h01249;
      6'd15:   r = 17'h01111;
      6'd16:   r = 17'h01000;
      6'd17:   r = 17'h00F0F;
      6'd18:   r = 17'h00E38;
      6'd19:   r = 17'h00D79;
      6'd20:   r = 17'h00CCC;
      6'd21:   r = 17'h00C30;
      6'd22:   r = 17'h00BA2;
      6'd23:   r = 17'h00B21;
      6'd24:   r = 17'h00AAA;
      6'd25:   r = 17'h00A3D;
      6'd26:   r = 17'h009D8;
      6'd27:   r = 17'h0097B;
      6'd28:   r = 17'h00924;
      6'd29:   r = 17'h008D3;
      6'd30:   r = 17'h00888;
      6'd31:   r = 17'h00842;
      default: r = '0;
    endcase
    return {{(SUM_W-FRAC_W-1){1'b0}}, r};
  endfunction

endpackage

`default_nettype wire

// File: rtl/harmonic_sum_ctrl.sv
// FSM controller: sequences LOAD, ACCUM and DONE with registered control outputs.
`default_nettype none

module harmonic_sum_ctrl
  import harmonic_sum_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic k_eq_n,
  input  logic n_is_zero,
  output logic n_en,
  output logic count_en,
  output logic add_en,
  output logic clear_datapath,
  output logic busy,
  output logic done
);

  state_t state_q;

  // Outputs are decoded from the next state so they line up with that state.
  always_ff @(posedge clk) begin
    n_en           <= 1'b0;
    count_en       <= 1'b0;
    add_en         <= 1'b0;
    clear_datapath <= 1'b0;
    busy           <= 1'b0;
    done           <= 1'b0;
    if (rst) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q        <= LOAD;
            n_en           <= 1'b1;
            clear_datapath <= 1'b1;
            busy           <= 1'b1;
          end
        end
        LOAD, ACCUM: begin
          busy <= 1'b1;
          if ((state_q == LOAD) ? n_is_zero : k_eq_n) begin
            state_q <= DONE;
            done    <= 1'b1;
          end else begin
            state_q  <= ACCUM;
            count_en <= 1'b1;
            add_en   <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/harmonic_sum_engine.sv
// Harmonic-sum datapath: n register, term counter, reciprocal ROM and Q4.16 accumulator.
`default_nettype none

module harmonic_sum_engine
  import harmonic_sum_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N_W-1:0]   n,
  output logic [SUM_W-1:0] sum,
  output logic             busy,
  output logic             done
);

  logic [N_W-1:0]   n_reg_q, n_reg_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [SUM_W-1:0] acc_q, acc_d;

  logic n_en, count_en, add_en, clear_datapath;
  logic k_eq_n, n_is_zero;

  // The zero test looks at the live input because LOAD decides before n_reg is written.
  assign n_is_zero = (n == '0);
  assign k_eq_n    = (k_q == {1'b0, n_reg_q});

  harmonic_sum_ctrl u_ctrl (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .k_eq_n         (k_eq_n),
    .n_is_zero      (n_is_zero),
    .n_en           (n_en),
    .count_en       (count_en),
    .add_en         (add_en),
    .clear_datapath (clear_datapath),
    .busy           (busy),
    .done           (done)
  );

  always_comb begin
    n_reg_d = n_reg_q;
    k_d     = k_q;
    acc_d   = acc_q;
    if (n_en)
      n_reg_d = n;
    if (clear_datapath) begin
      k_d   = K_W'(1);
      acc_d = '0;
    end else begin
      if (count_en)
        k_d = k_q + K_W'(1);
      if (add_en)
        acc_d = acc_q + recip(k_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_reg_q <= '0;
      k_q     <= '0;
      acc_q   <= '0;
    end else begin
      n_reg_q <= n_reg_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
    end
  end

  assign sum = acc_q;

endmodule

`default_nettype wire

// File: tb/tb_harmonic_sum_engine.sv
// Randomized self-checking bench for harmonic_sum_engine against an arithmetic H(n) model.
`default_nettype none

module tb_harmonic_sum_engine;

  logic        clk;
  logic        rst;
  logic        start;
  logic [4:0]  n;
  logic [19:0] sum;
  logic        busy;
  logic        done;

  int n_tests;
  int n_fail;

  harmonic_sum_engine dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .n     (n),
    .sum   (sum),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int model_h(input int nn);
    int s;
    s = 0;
    for (int k = 1; k <= nn; k++) s += 65536 / k;
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One computation: start held for `hold` edges; optionally scramble n during ACCUM.
  task automatic run(input int nv, input int hold, input bit scramble, input int exp_sum);
    int c;
    int hs;
    start = 1'b1;
    n     = 5'(nv);
    tick();
    c  = 0;
    hs = 1;
    if (hs >= hold) start = 1'b0;
    while (!done && c < 40) begin
      tick();
      c++;
      hs++;
      if (hs >= hold) start = 1'b0;
      if (c == 1) check("cleared_at_load", {12'b0, sum}, 32'd0);
      if (scramble) n = 5'($urandom_range(0, 31));
    end
    check("done_latency", c, nv + 1);
    check("sum", {12'b0, sum}, exp_sum);
    check("busy_in_done", {31'b0, busy}, 32'd1);
    start = 1'b0;
    tick();
    check("done_pulse_width", {31'b0, done}, 32'd0);
    check("busy_idle", {31'b0, busy}, 32'd0);
    check("sum_hold", {12'b0, sum}, exp_sum);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst   = 1'b1;
    start = 1'b0;
    n     = '0;
    tick();
    tick();

    // Reset with start high must win.
    start = 1'b1;
    tick();
    check("rst_sum", {12'b0, sum}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    rst   = 1'b0;
    start = 1'b0;
    tick();
    check("idle_busy", {31'b0, busy}, 32'd0);

    run(3, 2, 1'b0, 32'h1D555);
    check("model_h3", model_h(3), 32'h1D555);
    run(5, 1, 1'b0, 32'h24888);
    run(15, 1, 1'b0, 32'h35173);
    run(31, 1, 1'b0, 32'h406ED);
    run(0, 1, 1'b0, 0);
    run(9, 1, 1'b1, model_h(9));

    // Reset in the middle of an n = 15 run.
    start = 1'b1;
    n     = 5'd15;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("mid_busy_before_rst", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_sum", {12'b0, sum}, 32'd0);
    rst = 1'b0;
    begin
      bit saw_done;
      saw_done = 1'b0;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (done) saw_done = 1'b1;
      end
      check("mid_rst_no_done", {31'b0, saw_done}, 32'd0);
      check("mid_rst_stays_idle", {31'b0, busy}, 32'd0);
    end
    run(3, 1, 1'b0, 32'h1D555);

    // Randomized runs, some back to back, some with n changing mid-run.
    for (int t = 0; t < 24; t++) begin
      int nv;
      int gap;
      nv  = $urandom_range(0, 31);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) tick();
      run(nv, $urandom_range(1, 2), 1'($urandom_range(0, 1)), model_h(nv));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/harmonic_sum_engine.md
# harmonic_sum_engine

Sequential fixed-point harmonic-sum unit. On `start` it computes H(n) = 1/1 + 1/2 + … + 1/n for a 5-bit `n`, one term per clock. It presents the result on a 20-bit unsigned Q4.16 `sum`. It combines an FSM controller with a datapath made of an n register, a term counter, a reciprocal ROM, an adder and an accumulator.

## Interface
Parameters:
- None. Widths are fixed: N_W = 5, SUM_W = 20, FRAC_W = 16.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset. Synchronous, active-high. Overrides all other inputs.
- `start`  in  1  level request to begin a computation. Sampled only in IDLE.
- `n`  in  5  number of terms, 0..31. Latched in LOAD.
- `sum`  out  20  result in unsigned Q4.16. Valid from the DONE cycle until the next LOAD.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse in the DONE state.

## Operation
- FSM states are IDLE, LOAD, ACCUM and DONE.
- **IDLE**
  - If `start` = 1, go to LOAD.
  - Otherwise stay in IDLE and hold `sum`.
- **LOAD**
  - n_reg <= `n`, k <= 1, acc <= 0.
  - If `n` = 0, go to DONE. Otherwise go to ACCUM.
- **ACCUM**
  - Each cycle: acc <= acc + recip(k) and k <= k + 1.
  - The comparator asserts when k == n_reg. On that cycle the final term is added and the FSM goes to DONE.
- **DONE**
  - `done` = 1 for this cycle only, then go to IDLE.
- **Reciprocal ROM**
  - recip(1) = 0x10000.
  - recip(k) = floor(65536 / k) for k = 2..31.
  - Purely combinational, 17-bit entries zero-extended to 20 bits.
- **Arithmetic**
  - The accumulator is a 20-bit unsigned add.
  - The maximum result, H(31) = 0x406ED, is below 2^20, so overflow cannot occur and no saturation is required.
  - The counter k is 6 bits so it cannot wrap at n = 31.
- **Start and n handling**
  - `start` is ignored in LOAD, ACCUM and DONE.
  - If `start` is still high on return to IDLE, a new computation begins the following cycle.
  - Changes on `n` after LOAD have no effect.

## Timing
- **Reset values**
  - State is IDLE.
  - acc, k and n_reg are 0, so `sum` = 0.
  - `busy` = 0 and `done` = 0.
- **Latency**
  - Edge E0: `start` sampled high in IDLE.
  - E0 to E1: FSM is in LOAD.
  - E1 to E(n+1): FSM is in ACCUM for n cycles.
  - E(n+1): `done` rises and `sum` is final.
  - E(n+2): FSM is back in IDLE.
  - `done` is therefore high n+1 cycles after the sampling edge. For n = 0, `done` is high 1 cycle after LOAD.
- **Output stability**
  - `sum` shows partial accumulations during ACCUM.
  - `sum` is stable from DONE until the next LOAD clears it.
- **Reset mid-operation**
  - `rst` takes effect on the next edge from any state.
  - The FSM returns to IDLE, `sum` goes to 0 and no `done` pulse is generated.
- **Back-to-back runs**
  - The minimum start-to-start spacing is n+3 cycles.

## Structure
- Shared package `harmonic_sum_pkg` holds:
  - the state enum {IDLE, LOAD, ACCUM, DONE};
  - the constants N_W, SUM_W, FRAC_W;
  - the recip ROM function.
- Top module `harmonic_sum_engine` contains the datapath: n register, k counter, comparator, ROM, adder and accumulator.
- Sub-module `harmonic_sum_ctrl` holds the FSM.
  - Inputs: `clk`, `rst`, `start`, comparator output, n-is-zero.
  - Outputs: n_en, count_en, add_en, clear_datapath, `busy`, `done`.

## Test plan
- **Reset:** assert `rst` for 1 cycle with `start` high → `sum` = 0, `busy` = 0, `done` = 0. A run starts only after `rst` is released.
- **n = 3:** `start` held 2 cycles → `done` 4 cycles after the sampling edge, `sum` = 0x1D555 (120149). `sum` holds afterwards, including the second `start` cycle, which is ignored.
- **n = 5:** `start` held 1 cycle → `done` after 6 cycles, `sum` = 0x24888. **n = 15:** `sum` = 0x35173 after 16 cycles.
- **n = 31 and n = 0:** n = 31 → `sum` = 0x406ED with no overflow. n = 0 → `done` after 1 cycle with `sum` = 0.
- **Robustness:** change `n` during ACCUM → result unchanged. Assert `rst` midway through an n = 15 run → IDLE next cycle, `sum` = 0, no `done`; a fresh n = 3 run then gives 0x1D555.
